// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the BRAM Wishbone/DMA arbiter.
package bram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        REQ_WB  = 1'b0,
        REQ_DMA = 1'b1
    } req_e;

    localparam logic [7:0] BASE_PREFIX_DEF = 8'h38;

endpackage

// File: rtl/bram_arb_rr2.sv
// Two-input round-robin picker; the last-grant register moves only on i_upd.
module bram_arb_rr2
    import bram_arb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,       // bit0 = WB, bit1 = DMA
    input  logic       i_upd,
    input  req_e       i_upd_id,
    output req_e       o_gnt
);

    req_e r_last;

    // Reset to DMA so WB takes the first tie.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_last <= REQ_DMA;
        else if (i_upd)
            r_last <= i_upd_id;
    end

    always_comb begin
        o_gnt = REQ_WB;
        case (i_req)
            2'b10:   o_gnt = REQ_DMA;
            2'b11:   o_gnt = (r_last == REQ_WB) ? REQ_DMA : REQ_WB;
            default: o_gnt = REQ_WB;
        endcase
    end

endmodule

// File: rtl/bram_wb_arbiter.sv
// Shares one single-port BRAM between the Wishbone slave and a DMA word port,
// with programmable wait states. Optional counters under BRAM_ARB_STATS_EN.
module bram_wb_arbiter
    import bram_arb_pkg::*;
#(
    parameter int         ADDR_W      = 12,
    parameter int         DELAYS      = 10,
    parameter logic [7:0] BASE_PREFIX = BASE_PREFIX_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_adr_i,
    input  logic [31:0]       dma_dat_i,
    output logic              dma_gnt_o,
    output logic              dma_ack_o,
    output logic [31:0]       dma_dat_o,
`ifdef BRAM_ARB_STATS_EN
    output logic [15:0]       stat_wb_cnt_o,
    output logic [15:0]       stat_dma_cnt_o,
    output logic [15:0]       stat_conflict_cnt_o,
`endif
    output logic              bram_en_o,
    output logic [3:0]        bram_we_o,
    output logic [ADDR_W-1:0] bram_adr_o,
    output logic [31:0]       bram_di_o,
    input  logic [31:0]       bram_do_i
);

    localparam int                CNT_W  = (DELAYS > 1) ? $clog2(DELAYS) : 1;
    localparam logic [CNT_W-1:0]  W_LAST = CNT_W'((DELAYS > 0) ? DELAYS - 1 : 0);

    state_e              r_state, w_state_nxt;
    req_e                r_owner, w_gnt;
    logic [ADDR_W-1:0]   r_adr;
    logic [31:0]         r_di, r_rdata, r_wb_hold, r_dma_hold;
    logic [3:0]          r_we;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_wb_abort;
    logic                w_wb_req, w_any_req;
    logic                w_unused;

    assign w_wb_req  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_PREFIX);
    assign w_any_req = w_wb_req | dma_req_i;
    assign w_unused  = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

    bram_arb_rr2 u_rr (
        .i_clk    (wb_clk_i),
        .i_rst    (wb_rst_i),
        .i_req    ({dma_req_i, w_wb_req}),
        .i_upd    (r_state == RESP),
        .i_upd_id (r_owner),
        .o_gnt    (w_gnt)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= IDLE;
            r_owner    <= REQ_WB;
            r_adr      <= '0;
            r_di       <= '0;
            r_we       <= '0;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_wb_hold  <= '0;
            r_dma_hold <= '0;
            r_wb_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    r_cnt      <= '0;
                    r_wb_abort <= 1'b0;
                    if (w_any_req) begin
                        r_owner <= w_gnt;
                        if (w_gnt == REQ_WB) begin
                            r_adr <= wbs_adr_i[ADDR_W+1:2];
                            r_di  <= wbs_dat_i;
                            r_we  <= wbs_we_i ? wbs_sel_i : 4'h0;
                        end else begin
                            r_adr <= dma_adr_i;
                            r_di  <= dma_dat_i;
                            r_we  <= dma_we_i ? 4'hF : 4'h0;
                        end
                    end
                end
                CAPTURE: r_rdata <= bram_do_i;
                WAIT:    r_cnt   <= r_cnt + 1'b1;
                default: ;
            endcase
            // A WB master that drops cyc mid-access gets no ack, even if it re-raises cyc.
            if ((r_state inside {ACCESS, CAPTURE, WAIT}) && r_owner == REQ_WB && !wbs_cyc_i)
                r_wb_abort <= 1'b1;
            if (wbs_ack_o) r_wb_hold  <= r_rdata;
            if (dma_ack_o) r_dma_hold <= r_rdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        bram_en_o   = 1'b0;
        bram_we_o   = 4'h0;
        bram_adr_o  = '0;
        bram_di_o   = '0;
        dma_gnt_o   = 1'b0;
        wbs_ack_o   = 1'b0;
        dma_ack_o   = 1'b0;
        case (r_state)
            IDLE: if (w_any_req) w_state_nxt = ACCESS;
            ACCESS: begin
                bram_en_o   = 1'b1;
                bram_we_o   = r_we;
                bram_adr_o  = r_adr;
                bram_di_o   = r_di;
                dma_gnt_o   = (r_owner == REQ_DMA);
                w_state_nxt = CAPTURE;
            end
            CAPTURE: begin
                dma_gnt_o   = (r_owner == REQ_DMA);
                w_state_nxt = (DELAYS == 0) ? RESP : WAIT;
            end
            WAIT: begin
                dma_gnt_o = (r_owner == REQ_DMA);
                if (r_cnt == W_LAST) w_state_nxt = RESP;
            end
            RESP: begin
                dma_gnt_o   = (r_owner == REQ_DMA);
                wbs_ack_o   = (r_owner == REQ_WB) & ~r_wb_abort & wbs_cyc_i;
                dma_ack_o   = (r_owner == REQ_DMA);
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign wbs_dat_o = wbs_ack_o ? r_rdata : r_wb_hold;
    assign dma_dat_o = dma_ack_o ? r_rdata : r_dma_hold;

`ifdef BRAM_ARB_STATS_EN
    logic [15:0] r_stat_wb, r_stat_dma, r_stat_cfl;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_stat_wb  <= '0;
            r_stat_dma <= '0;
            r_stat_cfl <= '0;
        end else begin
            if (r_state == RESP && r_owner == REQ_WB && r_stat_wb != 16'hFFFF)
                r_stat_wb <= r_stat_wb + 16'd1;
            if (r_state == RESP && r_owner == REQ_DMA && r_stat_dma != 16'hFFFF)
                r_stat_dma <= r_stat_dma + 16'd1;
            if (r_state == IDLE && w_wb_req && dma_req_i && r_stat_cfl != 16'hFFFF)
                r_stat_cfl <= r_stat_cfl + 16'd1;
        end
    end

    assign stat_wb_cnt_o       = r_stat_wb;
    assign stat_dma_cnt_o      = r_stat_dma;
    assign stat_conflict_cnt_o = r_stat_cfl;
`endif

endmodule
